// File: rtl/l0_window_seq.sv
// l0_window_seq: 28x28 binary image buffer that feeds 3x3 windows to a
// convolution layer as strt + 9 serial bits. There are 26x26 = 676 windows
// per frame. Windows are walked column-inner, row-outer. The frame is
// flushed with clr.
module l0_window_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_vld,
    input  logic       pix_bit,
    input  logic       clr,
    input  logic       bsy_in,
    output logic       pix_rdy,
    output logic       strt,
    output logic       din,
    output logic       tx_done,
    output logic       frm_done,
    output logic [9:0] win_cnt
);

    localparam logic [9:0] LAST_PIX = 10'd783;
    localparam logic [9:0] NUM_WIN  = 10'd676;
    localparam logic [9:0] IMG_W    = 10'd28;
    localparam logic [4:0] LAST_POS = 5'd25;
    localparam logic [3:0] LAST_K   = 4'd8;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Offset of window bit k from the window's top-left pixel:
    // (k/3) rows down and (k%3) columns across.
    function automatic logic [9:0] win_offset(input logic [3:0] k);
        logic [9:0] off;
        case (k)
            4'd0:    off = 10'd0;
            4'd1:    off = 10'd1;
            4'd2:    off = 10'd2;
            4'd3:    off = 10'd28;
            4'd4:    off = 10'd29;
            4'd5:    off = 10'd30;
            4'd6:    off = 10'd56;
            4'd7:    off = 10'd57;
            4'd8:    off = 10'd58;
            default: off = 10'd0;
        endcase
        return off;
    endfunction

    state_t       state_q, state_d;
    logic [783:0] img_q, img_d;
    logic [9:0]   pix_cnt_q, pix_cnt_d;
    logic [4:0]   row_q, row_d;
    logic [4:0]   col_q, col_d;
    logic [3:0]   k_q, k_d;
    logic [9:0]   win_cnt_q, win_cnt_d;
    logic         strt_q, strt_d;
    logic         din_q, din_d;
    logic         tx_done_q, tx_done_d;
    logic [9:0]   rd_idx_s;
    logic         pix_wr_s;

    // Buffer index of the window bit currently being serialised.
    always_comb begin
        rd_idx_s = ({5'd0, row_q} * IMG_W) + {5'd0, col_q} + win_offset(k_q);
    end

    // A pixel is accepted only in LOAD and only when no clear is pending.
    always_comb begin
        pix_wr_s = (state_q == ST_LOAD) && pix_vld && !clr;
    end

    // Image buffer write port; clr never wipes stored pixels.
    always_comb begin
        img_d = img_q;
        if (pix_wr_s) begin
            img_d[pix_cnt_q] = pix_bit;
        end else begin
            img_d = img_q;
        end
    end

    // Next-state and next-output logic for the window sequencer.
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        k_d       = k_q;
        win_cnt_d = win_cnt_q;
        strt_d    = 1'b0;
        din_d     = 1'b0;
        tx_done_d = 1'b0;

        if (clr) begin
            // Flush: abort whatever is in flight and restart loading.
            state_d   = ST_LOAD;
            pix_cnt_d = 10'd0;
            row_d     = 5'd0;
            col_d     = 5'd0;
            k_d       = 4'd0;
            win_cnt_d = 10'd0;
            tx_done_d = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (pix_vld) begin
                        if (pix_cnt_q == LAST_PIX) begin
                            pix_cnt_d = 10'd0;
                            state_d   = ST_ISSUE;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 10'd1;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q;
                    end
                end
                ST_ISSUE: begin
                    if (!bsy_in) begin
                        strt_d  = 1'b1;
                        k_d     = 4'd0;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_SEND: begin
                    din_d = img_q[rd_idx_s];
                    if (k_q == LAST_K) begin
                        k_d       = 4'd0;
                        win_cnt_d = win_cnt_q + 10'd1;
                        state_d   = ST_WAIT;
                        if (col_q == LAST_POS) begin
                            col_d = 5'd0;
                            if (row_q == LAST_POS) begin
                                row_d = 5'd0;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
                ST_WAIT: begin
                    // At least one cycle here, so the layer can raise bsy_in.
                    if (!bsy_in) begin
                        if (win_cnt_q == NUM_WIN) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            pix_cnt_q <= 10'd0;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            k_q       <= 4'd0;
            win_cnt_q <= 10'd0;
            strt_q    <= 1'b0;
            din_q     <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            k_q       <= k_d;
            win_cnt_q <= win_cnt_d;
            strt_q    <= strt_d;
            din_q     <= din_d;
            tx_done_q <= tx_done_d;
        end
    end

    // Image storage; its contents after reset are don't-care.
    always_ff @(posedge clk) begin
        img_q <= img_d;
    end

    assign pix_rdy  = (state_q == ST_LOAD);
    assign frm_done = (state_q == ST_DONE);
    assign strt     = strt_q;
    assign din      = din_q;
    assign tx_done  = tx_done_q;
    assign win_cnt  = win_cnt_q;

endmodule

// File: tb/tb_l0_window_seq.sv
// Self-checking bench for l0_window_seq. The reference is an image array
// plus arithmetic on window coordinates. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_l0_window_seq;

    logic       clk;
    logic       rst_n;
    logic       pix_vld;
    logic       pix_bit;
    logic       clr;
    logic       bsy_in;
    logic       pix_rdy;
    logic       strt;
    logic       din;
    logic       tx_done;
    logic       frm_done;
    logic [9:0] win_cnt;

    int total;
    int bad;
    int frame_strts;
    bit img [0:783];

    l0_window_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_vld  (pix_vld),
        .pix_bit  (pix_bit),
        .clr      (clr),
        .bsy_in   (bsy_in),
        .pix_rdy  (pix_rdy),
        .strt     (strt),
        .din      (din),
        .tx_done  (tx_done),
        .frm_done (frm_done),
        .win_cnt  (win_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window w sits at row w/26, column w%26; bit k covers pixel (k/3, k%3).
    function automatic bit exp_bit(input int w, input int k);
        int r;
        int c;
        r = w / 26;
        c = w % 26;
        return img[(r + k / 3) * 28 + c + k % 3];
    endfunction

    task automatic drive_noise(input bit rnd);
        if (rnd) begin
            bsy_in  = ($urandom_range(0, 3) == 0);
            pix_vld = $urandom_range(0, 1);
            pix_bit = $urandom_range(0, 1);
        end else begin
            bsy_in  = 1'b0;
            pix_vld = 1'b0;
            pix_bit = 1'b0;
        end
    endtask

    task automatic load_img(input bit gaps);
        for (int p = 0; p < 784; p++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int i = 0; i < g; i++) begin
                    @(negedge clk);
                    pix_vld = 1'b0;
                    chk("rdy_gap", pix_rdy, 1);
                end
            end
            @(negedge clk);
            chk("rdy_load", pix_rdy, 1);
            pix_vld = 1'b1;
            pix_bit = img[p];
        end
        @(negedge clk);
        pix_vld = 1'b0;
        chk("rdy_after_load", pix_rdy, 0);
    endtask

    task automatic wait_strt(input bit rnd, input int exp_wait);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            chk("din_idle", din, 0);
            chk("tx_done_idle", tx_done, 0);
            chk("strt_vs_bsy", strt & bsy_in, 0);
            if (strt === 1'b1) seen = 1'b1;
            drive_noise(rnd);
        end
        chk("strt_seen", seen, 1);
        if (exp_wait > 0) chk("strt_gap", n, exp_wait);
        if (seen) frame_strts++;
    endtask

    task automatic send_bits(input int w, input bit rnd, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            chk("din_bit", din, exp_bit(w, k));
            chk("strt_in_send", strt, 0);
            if (k == 7) chk("win_cnt_pre", win_cnt, w);
            if (k == 8) chk("win_cnt_post", win_cnt, w + 1);
            drive_noise(rnd);
        end
    endtask

    task automatic run_windows(input int first, input int last, input bit rnd);
        for (int w = first; w <= last; w++) begin
            wait_strt(rnd, rnd ? 0 : ((w == 0) ? 1 : 2));
            send_bits(w, rnd, 9);
        end
    endtask

    task automatic finish_frame(input bit rnd);
        int n;
        n = 0;
        while (frm_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            chk("strt_after_last", strt, 0);
            drive_noise(rnd);
        end
        chk("frm_done", frm_done, 1);
        chk("win_cnt_final", win_cnt, 676);
        chk("frame_strts", frame_strts, 676);
        chk("rdy_in_done", pix_rdy, 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        pix_vld = 1'b0;
        bsy_in  = 1'b0;
        chk("clr_tx_done", tx_done, 1);
        chk("clr_rdy", pix_rdy, 1);
        chk("clr_win_cnt", win_cnt, 0);
        chk("clr_frm_done", frm_done, 0);
        chk("clr_strt", strt, 0);
        chk("clr_din", din, 0);
        @(negedge clk);
        chk("tx_done_single", tx_done, 0);
        chk("clr_din_after", din, 0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        frame_strts = 0;
        rst_n   = 1'b0;
        pix_vld = 1'b0;
        pix_bit = 1'b0;
        clr     = 1'b0;
        bsy_in  = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_rdy", pix_rdy, 1);
        chk("rst_strt", strt, 0);
        chk("rst_din", din, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_frm_done", frm_done, 0);
        chk("rst_win_cnt", win_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", pix_rdy, 1);

        // All-ones frame, layer never busy: full 676 windows at 11-cycle pitch.
        for (int p = 0; p < 784; p++) img[p] = 1'b1;
        frame_strts = 0;
        load_img(1'b0);
        run_windows(0, 675, 1'b0);
        finish_frame(1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("done_hold", frm_done, 1);
            chk("done_rdy", pix_rdy, 0);
            chk("done_strt", strt, 0);
            chk("done_din", din, 0);
            pix_vld = 1'b1;
            pix_bit = 1'b0;
        end
        pulse_clr();

        // Checkerboard, with the layer busy for 20 cycles on ISSUE entry.
        for (int p = 0; p < 784; p++) img[p] = ((p / 28) + (p % 28)) % 2;
        bsy_in = 1'b1;
        load_img(1'b0);
        repeat (20) begin
            @(negedge clk);
            chk("busy_no_strt", strt, 0);
            chk("busy_rdy", pix_rdy, 0);
        end
        bsy_in = 1'b0;
        @(negedge clk);
        chk("strt_after_bsy_fall", strt, 1);
        send_bits(0, 1'b0, 9);
        wait_strt(1'b0, 2);
        send_bits(1, 1'b0, 9);
        pulse_clr();

        // Clear together with a pixel strobe at pix_cnt = 300.
        for (int p = 0; p < 300; p++) begin
            @(negedge clk);
            pix_vld = 1'b1;
            pix_bit = $urandom_range(0, 1);
        end
        @(negedge clk);
        pix_vld = 1'b1;
        pix_bit = 1'b1;
        pulse_clr();

        // Random image with strobe gaps, then a frame under random busy and
        // stray pixel strobes; exact 784-pixel count proves the counter cleared.
        for (int p = 0; p < 784; p++) img[p] = $urandom_range(0, 1);
        frame_strts = 0;
        load_img(1'b1);
        run_windows(0, 675, 1'b1);
        finish_frame(1'b1);
        pulse_clr();

        // Abort window 100 at its 5th bit.
        for (int p = 0; p < 784; p++) img[p] = $urandom_range(0, 1);
        load_img(1'b0);
        run_windows(0, 99, 1'b0);
        wait_strt(1'b0, 2);
        send_bits(100, 1'b0, 5);
        pulse_clr();
        repeat (5) begin
            @(negedge clk);
            chk("abort_din", din, 0);
            chk("abort_strt", strt, 0);
            chk("abort_rdy", pix_rdy, 1);
        end

        // Asynchronous reset in the middle of window 5.
        for (int p = 0; p < 784; p++) img[p] = $urandom_range(0, 1);
        img[7] = 1'b1;
        load_img(1'b0);
        run_windows(0, 4, 1'b0);
        wait_strt(1'b0, 2);
        send_bits(5, 1'b0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_strt", strt, 0);
        chk("arst_din", din, 0);
        chk("arst_tx_done", tx_done, 0);
        chk("arst_frm_done", frm_done, 0);
        chk("arst_win_cnt", win_cnt, 0);
        chk("arst_rdy", pix_rdy, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", pix_rdy, 1);
        chk("post_rst_tx_done", tx_done, 0);

        // Fresh load after reset: inverted checkerboard.
        for (int p = 0; p < 784; p++) img[p] = ((p / 28) + (p % 28) + 1) % 2;
        load_img(1'b0);
        run_windows(0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l0_window_seq.md
L0_WINDOW_SEQ -- requirements
Module: l0_window_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port pix_vld, input, 1, image pixel strobe; sampled only when pix_rdy=1.
REQ-004 SHALL have port pix_bit, input, 1, binary pixel value, row-major over a 28x28 image.
REQ-005 SHALL have port clr, input, 1, frame clear/abort request.
REQ-006 SHALL have port bsy_in, input, 1, convolution layer busy flag; no strt may issue while high.
REQ-007 SHALL have port pix_rdy, output, 1, high only in LOAD.
REQ-008 SHALL have port strt, output, 1, registered one-cycle window-start pulse to the convolution layer.
REQ-009 SHALL have port din, output, 1, registered serial window bit to the convolution layer.
REQ-010 SHALL have port tx_done, output, 1, registered one-cycle frame flush pulse to layer and downstream.
REQ-011 SHALL have port frm_done, output, 1, level-high once all 676 windows are issued, until clr.
REQ-012 SHALL have port win_cnt, output, 10, number of windows fully issued in the current frame.

Function
REQ-013 SHALL hold a 784-bit image buffer, with pixel index p = row*28 + col.
REQ-014 SHALL use states LOAD, ISSUE, SEND, WAIT, DONE; reset state LOAD.
REQ-015 LOAD: each pix_vld writes pix_bit to buffer[pix_cnt] and increments pix_cnt; the write of index 783 moves to ISSUE next cycle.
REQ-016 ISSUE: when bsy_in=0, SHALL assert strt for one cycle, clear bit index k to 0, and move to SEND; while bsy_in=1, SHALL stay in ISSUE with strt=0.
REQ-017 SEND: SHALL drive din = buffer[(r + k/3)*28 + c + k%3] for k = 0..8, one bit per cycle, starting the cycle after strt; this is 9 consecutive cycles.
REQ-018 After k=8, SHALL move to WAIT with din=0, and increment win_cnt.
REQ-019 WAIT: SHALL remain one cycle minimum and then until bsy_in=0; then ISSUE if windows remain, else DONE.
REQ-020 Window order: c = 0..25 inner, r = 0..25 outer; after c=25, c wraps to 0 and r increments; after (25,25), no further strt issues.
REQ-021 DONE: frm_done=1, strt=0, din=0, pix_rdy=0; SHALL hold until clr.
REQ-022 clr in any state SHALL pulse tx_done exactly one cycle later, zero pix_cnt/r/c/k/win_cnt, drop frm_done, and enter LOAD; buffer contents are not cleared.
REQ-023 clr SHALL win over a simultaneous pix_vld; that pixel is discarded.
REQ-024 clr during SEND SHALL abort the window; no further din bits issue and win_cnt is not incremented.
REQ-025 pix_vld outside LOAD SHALL be ignored.
REQ-026 Latency: minimum per-window period is 11 cycles (strt + 9 bits + 1 WAIT) when bsy_in stays low after WAIT entry.
REQ-027 All outputs SHALL be registered, except pix_rdy and frm_done, which decode the state register directly.

Reset
REQ-028 On rst_n=0 (asynchronous), SHALL set state=LOAD, strt=0, din=0, tx_done=0, frm_done=0, win_cnt=0, and pix_cnt=r=c=k=0; buffer content is undefined.
REQ-029 Reset asserted mid-SEND SHALL abort immediately with no tx_done pulse; after release, pix_rdy=1 on the first clock.

Verification
REQ-030 Load 784 ones with bsy_in=0 -> strt at the cycle after ISSUE entry, followed by din=1 for 9 cycles; win_cnt=1 after the first window; 676 strt pulses total; frm_done=1 and win_cnt=676.
REQ-031 Load a checkerboard (pixel = (row+col)%2) -> window (0,0) din sequence 0,1,0,1,0,1,0,1,0; window (0,1) is the inverse.
REQ-032 Hold bsy_in=1 for 20 cycles in ISSUE -> no strt; strt occurs the cycle after bsy_in falls.
REQ-033 Assert clr at the 5th din bit of window 100 -> no further din bits, tx_done pulse next cycle, win_cnt=0, pix_rdy=1.
REQ-034 Assert pix_vld and clr together in LOAD at pix_cnt=300 -> pix_cnt=0 afterwards, and the pixel is not written.
REQ-035 Drop rst_n mid-frame -> all outputs reach their reset values without a clock edge; a fresh 784-pixel load is accepted.
